// File: rtl/gardner_shift_ctrl_if.sv
// I/Q sample stream bundle feeding the Gardner pre-shift controller.
interface gardner_shift_ctrl_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] I_in_tdata;
    logic                    I_in_tvalid;
    logic signed [WIDTH-1:0] Q_in_tdata;
    logic                    Q_in_tvalid;

    modport master (output I_in_tdata, output I_in_tvalid, output Q_in_tdata, output Q_in_tvalid);
    modport slave  (input  I_in_tdata, input  I_in_tvalid, input  Q_in_tdata, input  Q_in_tvalid);
endinterface

// File: rtl/gardner_shift_ctrl.sv
// Windowed peak-magnitude measurement that steps the I/Q pre-shift by at most one per window.
// Optional lock detector: define GARDNER_SHIFT_CTRL_LOCK_EN.
//
//  state   | meaning
//  IDLE    | waiting for en, window cleared
//  MEASURE | accepting samples, tracking running peak
//  DECIDE  | comparing peak>>shift against the target band
//  APPLY   | committing shift/peak, pulsing shift_update
module gardner_shift_ctrl #(
    parameter int WIDTH      = 16,
    parameter int WIN_LOG2   = 8,
    parameter int SHIFT_INIT = 2,
    parameter int SHIFT_MAX  = 7,
    parameter int TGT_HI     = 4095,
    parameter int TGT_LO     = 1024,
    parameter int LOCK_WINS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    gardner_shift_ctrl_if.slave     s_in,
    output logic [2:0]              shift_out,
    output logic                    shift_update,
    output logic [WIDTH-2:0]        peak_out,
    output logic                    locked
);

    if (TGT_LO >= TGT_HI || LOCK_WINS < 1 || SHIFT_INIT > SHIFT_MAX || SHIFT_MAX > 7) begin : g_param_check
        $error("gardner_shift_ctrl: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, APPLY} state_t;

    localparam logic [2:0]  SHIFT_INIT_L = 3'(SHIFT_INIT);
    localparam logic [2:0]  SHIFT_MAX_L  = 3'(SHIFT_MAX);
    localparam logic [31:0] TGT_HI_L     = 32'(TGT_HI);
    localparam logic [31:0] TGT_LO_L     = 32'(TGT_LO);

    state_t                state_q, state_d;
    logic [WIN_LOG2-1:0]   cnt_q;
    logic [WIDTH-2:0]      peak_q;
    logic [WIDTH-2:0]      mag_i, mag_q, mag;
    logic [2:0]            shift_dec_q;
    logic [31:0]           scaled;
    logic                  accept, win_last, step_up, step_dn;

    // |x| with the most-negative code saturated so it fits in WIDTH-1 bits
    function automatic logic [WIDTH-2:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] n;
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            n = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (x[WIDTH-1]) begin
            n = -x;
        end else begin
            n = x;
        end
        return n[WIDTH-2:0];
    endfunction

    assign mag_i    = abs_sat(s_in.I_in_tdata);
    assign mag_q    = abs_sat(s_in.Q_in_tdata);
    assign mag      = (mag_i > mag_q) ? mag_i : mag_q;
    assign accept   = (state_q == MEASURE) && en && s_in.I_in_tvalid && s_in.Q_in_tvalid;
    assign win_last = &cnt_q;

    assign scaled  = 32'(peak_q >> shift_out);
    assign step_up = (scaled > TGT_HI_L) && (shift_out < SHIFT_MAX_L);
    assign step_dn = !step_up && (scaled < TGT_LO_L) && (shift_out != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = MEASURE;
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (accept && win_last) begin
                    state_d = DECIDE;
                end
            end
            DECIDE:  state_d = APPLY;
            APPLY:   state_d = en ? MEASURE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            peak_q       <= '0;
            shift_dec_q  <= SHIFT_INIT_L;
            shift_out    <= SHIFT_INIT_L;
            peak_out     <= '0;
            shift_update <= 1'b0;
        end else begin
            shift_update <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    peak_q <= '0;
                end
                MEASURE: begin
                    if (!en) begin
                        cnt_q  <= '0;
                        peak_q <= '0;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (mag > peak_q) peak_q <= mag;
                    end
                end
                DECIDE: begin
                    if (step_up) begin
                        shift_dec_q <= shift_out + 3'd1;
                    end else if (step_dn) begin
                        shift_dec_q <= shift_out - 3'd1;
                    end else begin
                        shift_dec_q <= shift_out;
                    end
                end
                APPLY: begin
                    shift_out    <= shift_dec_q;
                    peak_out     <= peak_q;
                    shift_update <= 1'b1;
                    cnt_q        <= '0;
                    peak_q       <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef GARDNER_SHIFT_CTRL_LOCK_EN
    localparam int         LCW    = $clog2(LOCK_WINS + 1);
    localparam logic [LCW-1:0] LOCK_WINS_L = LCW'(LOCK_WINS);

    logic [LCW-1:0] lock_cnt_q;

    // count saturates at LOCK_WINS, so locked simply stays set once reached
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            locked     <= 1'b0;
        end else if (state_q == APPLY) begin
            if (shift_dec_q != shift_out) begin
                lock_cnt_q <= '0;
                locked     <= 1'b0;
            end else if (lock_cnt_q != LOCK_WINS_L) begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
                locked     <= (lock_cnt_q == LOCK_WINS_L - 1'b1);
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_gardner_shift_ctrl.sv
// Self-checking bench: window-level reference model compared every cycle, plus literal scenario checks.
module tb_gardner_shift_ctrl;
    localparam int WIDTH      = 16;
    localparam int WIN_LOG2   = 4;
    localparam int N          = 1 << WIN_LOG2;
    localparam int SHIFT_INIT = 2;
    localparam int SHIFT_MAX  = 7;
    localparam int TGT_HI     = 4095;
    localparam int TGT_LO     = 1024;
    localparam int LOCK_WINS  = 3;
    localparam int MAG_MAX    = (1 << (WIDTH - 1)) - 1;
`ifdef GARDNER_SHIFT_CTRL_LOCK_EN
    localparam int LOCK_ON = 1;
`else
    localparam int LOCK_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [2:0]       shift_out;
    logic             shift_update;
    logic [WIDTH-2:0] peak_out;
    logic             locked;

    gardner_shift_ctrl_if #(.WIDTH(WIDTH)) bus ();

    gardner_shift_ctrl #(
        .WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2), .SHIFT_INIT(SHIFT_INIT), .SHIFT_MAX(SHIFT_MAX),
        .TGT_HI(TGT_HI), .TGT_LO(TGT_LO), .LOCK_WINS(LOCK_WINS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .s_in(bus),
        .shift_out(shift_out), .shift_update(shift_update), .peak_out(peak_out), .locked(locked)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: tracks accepted samples per window; a completed window
    // takes effect two edges later, during which no samples are taken.
    bit m_valid = 0;
    bit m_active, m_pulse, m_locked;
    int m_cnt, m_peak, m_wpeak, m_pend, m_shift, m_peak_out, m_lockcnt;

    function automatic int mag(input int x);
        int a;
        a = (x < 0) ? -x : x;
        return (a > MAG_MAX) ? MAG_MAX : a;
    endfunction

    task automatic model_apply();
        int scaled, ns;
        scaled = m_wpeak / (1 << m_shift);
        ns = m_shift;
        if (scaled > TGT_HI && m_shift < SHIFT_MAX) ns = m_shift + 1;
        else if (scaled < TGT_LO && m_shift > 0) ns = m_shift - 1;
        if (LOCK_ON != 0) begin
            if (ns != m_shift) begin
                m_lockcnt = 0;
                m_locked  = 0;
            end else begin
                if (m_lockcnt < LOCK_WINS) m_lockcnt++;
                if (m_lockcnt == LOCK_WINS) m_locked = 1;
            end
        end
        m_shift    = ns;
        m_peak_out = m_wpeak;
        m_pulse    = 1;
        m_active   = en;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_active = 0; m_cnt = 0; m_peak = 0; m_wpeak = 0; m_pend = 0;
            m_shift = SHIFT_INIT; m_peak_out = 0; m_pulse = 0; m_locked = 0; m_lockcnt = 0;
        end else if (m_valid) begin
            m_pulse = 0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) model_apply();
            end else if (!m_active) begin
                m_active = en;
            end else if (!en) begin
                m_active = 0; m_cnt = 0; m_peak = 0;
            end else if (bus.I_in_tvalid && bus.Q_in_tvalid) begin
                int m;
                m = mag(int'(bus.I_in_tdata));
                if (mag(int'(bus.Q_in_tdata)) > m) m = mag(int'(bus.Q_in_tdata));
                if (m > m_peak) m_peak = m;
                m_cnt++;
                if (m_cnt == N) begin
                    m_wpeak = m_peak; m_cnt = 0; m_peak = 0; m_pend = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_shift_out", int'(shift_out), m_shift);
            check("model_peak_out", int'(peak_out), m_peak_out);
            check("model_shift_update", int'(shift_update), int'(m_pulse));
            check("model_locked", int'(locked), int'(m_locked));
        end
    end

    task automatic set_in(input bit e, input bit iv, input bit qv, input int i, input int q);
        en = e;
        bus.I_in_tvalid = iv;
        bus.Q_in_tvalid = qv;
        bus.I_in_tdata  = WIDTH'(i);
        bus.Q_in_tdata  = WIDTH'(q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!shift_update && cyc < 100);
        if (!shift_update) begin
            total++;
            $display("FAIL pulse_wait: no shift_update within %0d cycles", cyc);
        end
    endtask

    int cyc;
    int amp;
    int amps [5] = '{300, 2000, 6000, 20000, 32767};

    initial begin
        set_in(0, 0, 0, 0, 0);
        do_reset();
        check("rst_shift_out", int'(shift_out), 2);
        check("rst_peak_out", int'(peak_out), 0);
        check("rst_shift_update", int'(shift_update), 0);
        check("rst_locked", int'(locked), 0);

        // large constant I: one step up, then in band
        set_in(1, 1, 1, 20000, 0);
        wait_pulse(cyc);
        check("big_first_latency", cyc, 19);
        check("big_first_shift", int'(shift_out), 3);
        check("big_first_peak", int'(peak_out), 20000);
        wait_pulse(cyc);
        check("big_next_latency", cyc, 18);
        check("big_next_shift", int'(shift_out), 3);

        // small constant I=Q: steps down to zero and stays
        do_reset();
        set_in(1, 1, 1, 300, 300);
        wait_pulse(cyc);
        check("small_w1_shift", int'(shift_out), 1);
        wait_pulse(cyc);
        check("small_w2_shift", int'(shift_out), 0);
        wait_pulse(cyc);
        check("small_w3_shift", int'(shift_out), 0);
        check("small_w3_peak", int'(peak_out), 300);

        // single most-negative Q sample
        do_reset();
        set_in(1, 1, 1, 0, -32768);
        @(negedge clk);
        @(negedge clk);
        set_in(1, 1, 1, 0, 0);
        wait_pulse(cyc);
        check("minneg_peak", int'(peak_out), 32767);
        check("minneg_shift", int'(shift_out), 3);

        // reset mid-window
        do_reset();
        set_in(1, 1, 1, 20000, 0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_shift", int'(shift_out), 2);
        check("midrst_no_pulse", int'(shift_update), 0);
        rst = 1'b0;
        wait_pulse(cyc);
        check("midrst_latency", cyc, 19);

        // en dropped mid-window
        do_reset();
        set_in(1, 1, 1, 20000, 0);
        repeat (11) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("endrop_shift", int'(shift_out), 2);
        check("endrop_no_pulse", int'(shift_update), 0);
        en = 1'b1;
        wait_pulse(cyc);
        check("endrop_latency", cyc, 19);

        // lock detection: 5000>>2 = 1250 is in band, so shift holds at 2
        do_reset();
        set_in(1, 1, 1, 5000, 0);
        wait_pulse(cyc);
        check("lock_w1", int'(locked), 0);
        wait_pulse(cyc);
        check("lock_w2", int'(locked), 0);
        wait_pulse(cyc);
        check("lock_w3", int'(locked), LOCK_ON);
        check("lock_w3_shift", int'(shift_out), 2);
        set_in(1, 1, 1, 30000, 0);
        wait_pulse(cyc);
        check("lock_step_shift", int'(shift_out), 3);
        check("lock_step_cleared", int'(locked), 0);

        // randomized traffic against the model
        amp = 2000;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (c % 48 == 0) amp = amps[$urandom_range(0, 4)];
            rst = ($urandom_range(0, 399) == 0);
            en  = en ? ($urandom_range(0, 99) >= 2) : ($urandom_range(0, 99) < 20);
            bus.I_in_tvalid = ($urandom_range(0, 99) < 85);
            bus.Q_in_tvalid = ($urandom_range(0, 99) < 90);
            bus.I_in_tdata  = WIDTH'(int'($urandom_range(0, 2 * amp)) - amp);
            bus.Q_in_tdata  = WIDTH'(int'($urandom_range(0, 2 * amp)) - amp);
            if ($urandom_range(0, 499) == 0) bus.Q_in_tdata = WIDTH'(-32768);
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
